// File: rtl/perturb_engine.sv
// Mutation stage of the GA datapath: flips at most one pseudo-random bit per
// 8-bit trait of the crossover gene, driven by a free-running 32-bit LFSR.
module perturb_engine #(
  parameter int          GENE_W    = 32,
  parameter int          TRAIT_W   = 8,
  parameter logic [31:0] LFSR_SEED = 32'h0000_0001,
  parameter int          MUT_RATE  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [GENE_W-1:0] crossover_gene,
  output logic [GENE_W-1:0] child_gene
);

  localparam int          N_TRAITS = GENE_W / TRAIT_W;
  // A zero seed would lock the LFSR at zero forever, so it is replaced by 1.
  localparam logic [31:0] SEED     = (LFSR_SEED == 32'h0) ? 32'h1 : LFSR_SEED;
  localparam logic [5:0]  RATE     = 6'(MUT_RATE);

  logic [31:0]       lfsr_q, lfsr_d;
  logic [GENE_W-1:0] child_q, child_d;
  logic [7:0]        r_byte;
  logic [TRAIT_W-1:0] flip_mask;

  // NOTE: every signal written here gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    lfsr_d    = {lfsr_q[30:0], lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0]};
    child_d   = crossover_gene;
    r_byte    = 8'h00;
    flip_mask = '0;
    for (int i = 0; i < N_TRAITS; i++) begin
      r_byte    = lfsr_q[i*8 +: 8];
      flip_mask = ({1'b0, r_byte[7:3]} < RATE) ? (TRAIT_W'(1) << r_byte[2:0]) : '0;
      child_d[i*TRAIT_W +: TRAIT_W] = crossover_gene[i*TRAIT_W +: TRAIT_W] ^ flip_mask;
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_q  <= SEED;
      child_q <= '0;
    end else begin
      lfsr_q  <= lfsr_d;
      child_q <= child_d;
    end
  end

  assign child_gene = child_q;

endmodule

// File: tb/tb_perturb_engine.sv
// Directed and long-run checks of perturb_engine at mutation rates 4, 0 and 32.
module tb_perturb_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] gene;
  logic [31:0] child_def, child_off, child_all;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] lfsr_m;
  logic [31:0] exp_def;
  logic [31:0] diff;
  int          hits;

  always #5 clk = ~clk;

  perturb_engine #(.MUT_RATE(4)) dut_def (
    .clk(clk), .rst(rst), .crossover_gene(gene), .child_gene(child_def)
  );
  perturb_engine #(.MUT_RATE(0)) dut_off (
    .clk(clk), .rst(rst), .crossover_gene(gene), .child_gene(child_off)
  );
  perturb_engine #(.MUT_RATE(32)) dut_all (
    .clk(clk), .rst(rst), .crossover_gene(gene), .child_gene(child_all)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] lfsr_next(input logic [31:0] l);
    return {l[30:0], l[31] ^ l[21] ^ l[1] ^ l[0]};
  endfunction

  function automatic logic [31:0] model_child(input logic [31:0] g, input logic [31:0] l,
                                              input int rate);
    logic [31:0] res;
    logic [7:0]  r;
    res = g;
    for (int t = 0; t < 4; t++) begin
      r = l[8*t +: 8];
      if (int'(r[7:3]) < rate) res[8*t + int'(r[2:0])] = ~res[8*t + int'(r[2:0])];
    end
    return res;
  endfunction

  task automatic run_directed(input string tag);
    logic [31:0] exp_seq [3];
    exp_seq[0] = 32'h05020303;
    exp_seq[1] = 32'h05020309;
    exp_seq[2] = 32'h05020341;
    gene = 32'h04030201;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check($sformatf("%s_def_edge%0d", tag, k + 1), child_def, exp_seq[k]);
      check($sformatf("%s_all_edge%0d", tag, k + 1), child_all, exp_seq[k]);
      check($sformatf("%s_off_edge%0d", tag, k + 1), child_off, 32'h04030201);
      lfsr_m = lfsr_next(lfsr_m);
    end
  endtask

  initial begin
    rst    = 1'b0;
    gene   = 32'h04030201;
    lfsr_m = 32'h1;
    hits   = 0;

    // Reset held across several edges with a live input.
    repeat (3) begin
      @(posedge clk); #1;
      check("rst_hold_def", child_def, 32'h0);
      check("rst_hold_off", child_off, 32'h0);
      check("rst_hold_all", child_all, 32'h0);
      check("rst_hold_no_x", {31'b0, $isunknown({child_def, child_off, child_all})}, 32'h0);
    end
    #1 rst = 1'b1;

    run_directed("post_rst");

    // Long random run: exact model for rate 4, identity for rate 0,
    // exactly one flip per trait for rate 32.
    for (int c = 0; c < 10000; c++) begin
      gene    = $urandom;
      exp_def = model_child(gene, lfsr_m, 4);
      @(posedge clk); #1;
      check("run_def_model", child_def, exp_def);
      check("run_off_passthru", child_off, gene);
      diff = child_def ^ gene;
      for (int t = 0; t < 4; t++) begin
        check("run_def_pop_le1", {31'b0, $countones(diff[8*t +: 8]) <= 1}, 32'h1);
        check("run_all_pop_eq1", 32'($countones(child_all[8*t +: 8] ^ gene[8*t +: 8])), 32'h1);
        if (diff[8*t +: 8] != 8'h00) hits++;
      end
      lfsr_m = lfsr_next(lfsr_m);
    end
    // 40000 trait trials at 1/8 probability, +/-2% band.
    check("mut_freq_in_band", {31'b0, (hits >= 4200) && (hits <= 5800)}, 32'h1);

    // Asynchronous reset pulse between edges.
    rst = 1'b0;
    #1;
    check("mid_rst_def", child_def, 32'h0);
    check("mid_rst_off", child_off, 32'h0);
    check("mid_rst_all", child_all, 32'h0);
    #1 rst = 1'b1;
    lfsr_m = 32'h1;
    run_directed("mid_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/perturb_engine.md
# perturb_engine

Mutation (perturbation) stage of the genetic-algorithm datapath. It takes a 32-bit crossover gene made of four 8-bit traits and produces a registered 32-bit child gene. Each trait independently has a pseudo-random single bit flipped, driven by an on-chip 32-bit LFSR and a programmable mutation rate. The block sits directly after the crossover engine and feeds the child-gene population store.

## Interface
- GENE_W, 32: gene width; fixed at 4 traits × TRAIT_W.
- TRAIT_W, 8: trait width.
- LFSR_SEED, 32'h0000_0001: LFSR reset value; a seed of 0 is replaced by 32'h1.
- MUT_RATE, 4: mutation threshold, range 0..32; per-trait mutation probability is MUT_RATE/32.

Ports:
- clk  in  1  single clock; rising-edge active.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- crossover_gene  in  32  parent gene from crossover; trait i = bits [8i+7:8i], i = 0..3.
- child_gene  out  32  registered mutated gene.

## Operation
- The LFSR is a 32-bit Fibonacci register with taps 32,22,2,1.
  - fb = L[31]^L[21]^L[1]^L[0].
  - next L = {L[30:0], fb}.
- The LFSR advances on every clock edge while out of reset.
- For each trait i, the random byte is r_i = L[8i+7:8i], taken from the current (pre-advance) LFSR value.
- Mutate decision: mutate_i = ({1'b0, r_i[7:3]} < MUT_RATE).
  - MUT_RATE = 0 means never mutate.
  - MUT_RATE = 32 means always mutate.
- Bit index: idx_i = r_i[2:0].
- Trait result: child_trait_i = crossover_trait_i XOR (mutate_i ? (8'b1 << idx_i) : 8'b0).
- At most one bit flips per trait, and no carries cross between traits.
- child_gene = {child_trait_3, child_trait_2, child_trait_1, child_trait_0}, registered.
- There is no handshake. The block is free-running and produces one result per clock.

## Timing
- Reset (rst = 0, asynchronous): child_gene is cleared to 32'h0 immediately and the LFSR loads LFSR_SEED (or 32'h1 if the seed is 0). Both hold for as long as reset is asserted.
- First rising edge after rst returns to 1:
  - child_gene is computed from the current crossover_gene and the seed value.
  - The LFSR moves to its next state.
- Latency: 1 cycle. crossover_gene is sampled at the rising edge and child_gene updates at that same edge.
- The input must be stable across each edge. An input change between edges has no effect until the next edge.
- Reset asserted mid-operation: output clears and the LFSR reloads asynchronously. The sequence after reset repeats exactly, so the output is deterministic for a given seed and input stream.
- The LFSR never reaches the all-zero state: it is nonzero at reset, and the tap set is maximal-length.

## Test plan
- Reset hold: keep rst = 0 for 20 ns with crossover_gene = 32'h04030201 -> child_gene = 32'h0 throughout, with no X values.
- Default parameters, release reset, crossover_gene = 32'h04030201:
  - edge 1 (LFSR = 32'h1) -> child_gene = 32'h05020303;
  - edge 2 (LFSR = 32'h3) -> child_gene = 32'h05020309;
  - edge 3 (LFSR = 32'h6) -> child_gene = 32'h05020341.
- MUT_RATE = 0, any input over 1000 cycles -> child_gene equals crossover_gene delayed by 1 cycle.
- MUT_RATE = 32 -> every cycle, each trait of child_gene XOR crossover_gene (delayed) has exactly one bit set.
- Default rate, long run of 10,000 cycles -> every trait XOR difference has popcount 0 or 1. The mutation frequency per trait is about 12.5% (±2%).
- Mid-run async reset: pulse rst low between edges -> child_gene = 0 immediately. After release, the sequence matches the post-reset sequence above exactly.
